mem_unit: RTL and testbench

MEM_UNIT -- requirements
Module: mem_unit

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_unit.sv | 145 ++++++++++++++
 tb/tb_mem_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable memory unit: access-size codes,
// FSM state encoding and the byte-lane enable helper.
package mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;   // 2'b11 also decodes as byte

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Byte enables of a little-endian access; halfwords ignore offset bit 0.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        if ((size & SZ_BYTE) == SZ_BYTE) begin
            m = 4'b0001 << off;
        end else if (size == SZ_HALF) begin
            m = off[1] ? 4'b1100 : 4'b0011;
        end else begin
            m = 4'b1111;
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and sign/zero-extends load data from a
// memory word, and merges right-justified store data into the word read back.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_wr_word
);

    logic        w_is_byte;
    logic [1:0]  w_lane;
    logic [31:0] w_shifted;
    logic [31:0] w_wr_rep;
    logic [3:0]  w_mask;

    assign w_is_byte = ((i_size & SZ_BYTE) == SZ_BYTE);

    always_comb begin
        w_lane   = 2'b00;
        w_wr_rep = i_wdata;
        if (w_is_byte) begin
            w_lane   = i_offset;
            w_wr_rep = {LANES{i_wdata[7:0]}};
        end else if (i_size == SZ_HALF) begin
            w_lane   = {i_offset[1], 1'b0};
            w_wr_rep = {2{i_wdata[15:0]}};
        end
    end

    assign w_shifted = i_rd_word >> {w_lane, 3'b000};

    always_comb begin
        o_ld_data = w_shifted;
        if (w_is_byte) begin
            o_ld_data = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
        end else if (i_size == SZ_HALF) begin
            o_ld_data = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
        end
    end

    assign w_mask = lane_mask(i_size, i_offset);

    // Store data is replicated across lanes so each lane only needs a 2:1 mux.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign o_wr_word[gi*LANE_W +: LANE_W] = w_mask[gi] ? w_wr_rep[gi*LANE_W +: LANE_W]
                                                               : i_rd_word[gi*LANE_W +: LANE_W];
        end
    endgenerate

endmodule

// File: rtl/mem_unit.sv
// Single-port 32-bit word memory with byte/half/word loads and stores, three-cycle
// request/response handshake. Define MEM_MISALIGN_TRAP_EN to reject misaligned accesses.
module mem_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t r_state;
    state_t w_state_next;

    logic              w_ready;
    logic              w_accept;
    logic [IDX_W-1:0]  w_idx;
    logic              w_range_err;
    logic              w_misalign;
    logic              w_err;
    logic              w_write;
    logic [31:0]       w_ld_data;
    logic [31:0]       w_wr_word;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_offset;
    logic [MEM_AW-1:0] r_idx;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_rd_word;

    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;

    assign w_idx       = req_addr[ADDR_W-1:2];
    assign w_range_err = (32'(w_idx) >= 32'(DEPTH));

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err    = w_range_err || w_misalign;
    assign w_accept = req_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = rst_n;
                if (req_valid && rst_n) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_next = ST_RESP;
            ST_RESP:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign req_ready = w_ready;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_offset   <= req_addr[1:0];
            r_idx      <= w_idx[MEM_AW-1:0];
            r_wdata    <= req_wdata;
            r_err      <= w_err;
        end
    end

    // An async reset drops the FSM out of ACCESS, which cancels a pending write.
    assign w_write = (r_state == ST_ACCESS) && r_we && !r_err;

    always_ff @(posedge clk) begin
        if (w_accept && !w_range_err) begin
            r_rd_word <= r_mem[w_idx[MEM_AW-1:0]];
        end
        if (w_write) begin
            r_mem[r_idx] <= w_wr_word;
        end
    end

    mem_lane_align u_lane_align (
        .i_rd_word  (r_rd_word),
        .i_size     (r_size),
        .i_offset   (r_offset),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_ld_data  (w_ld_data),
        .o_wr_word  (w_wr_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_rsp_valid <= (r_state == ST_ACCESS);
            if (r_state == ST_ACCESS) begin
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (r_we || r_err) ? 32'h0 : w_ld_data;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: directed scenarios plus random traffic against a
// byte-array reference model; honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_unit;
    import mem_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 32;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    mem_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cyc  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] model [256];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, extension by plain arithmetic.
    function automatic void model_access(input bit we, input logic [1:0] size, input bit uns,
                                         input logic [7:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] rdata, output bit err);
        int     nb;
        int     a;
        int     base;
        longint v;
        a     = int'(addr);
        nb    = (size == SZ_WORD) ? 4 : (size == SZ_HALF) ? 2 : 1;
        base  = a - (a % nb);
        err   = ((a / 4) >= DEPTH);
`ifdef MEM_MISALIGN_TRAP_EN
        if ((a % nb) != 0) err = 1'b1;
`endif
        rdata = 32'h0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) model[base + i] = wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v + (longint'(model[base + i]) << (8 * i));
            if (!uns && model[base + nb - 1][7]) v = v - (longint'(1) << (8 * nb));
            rdata = v[31:0];
        end
    endfunction

    task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input bit use_const = 1'b0, input logic [31:0] c_rdata = 32'h0,
                         input bit c_err = 1'b0, input bit expect_rsp = 1'b1);
        exp_t        e;
        logic [31:0] m_rd;
        bit          m_err;
        int          waited;
        waited = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: req_ready=0 after %0d cycles, want 1", waited);
            return;
        end
        acc_cyc = cyc;
        if (expect_rsp) begin
            model_access(we, size, uns, addr, wdata, m_rd, m_err);
            e.rdata = use_const ? c_rdata : m_rd;
            e.err   = use_const ? c_err : m_err;
            e.cyc   = cyc + 2;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        idle(0);
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check32("drain_outstanding", 32'(exp_q.size()), 32'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding, want 0");
            end else begin
                mon_e = exp_q.pop_front();
                check32("rsp_rdata", rsp_rdata, mon_e.rdata);
                check32("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
                check32("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                $display("rsp cyc=%0d rdata=%h err=%0d (want %h/%0d)",
                         cyc, rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        int a2;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr     = 8'h0;
        req_wdata    = 32'h0;
        repeat (3) @(negedge clk);
        check32("reset_req_ready", {31'b0, req_ready}, 32'h0);
        check32("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check32("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
        check32("reset_rsp_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check32("ready_after_reset", {31'b0, req_ready}, 32'h1);

        for (int w = 0; w < DEPTH; w++) issue(1'b1, SZ_WORD, 1'b0, 8'(w * 4), 32'h0);

        issue(1'b1, SZ_WORD, 1'b0, 8'h04, 32'h11223344, 1'b1, 32'h0, 1'b0);
        issue(1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0, 1'b1, 32'h11223344, 1'b0);
        issue(1'b1, SZ_BYTE, 1'b0, 8'h06, 32'h000000AA, 1'b1, 32'h0, 1'b0);
        issue(1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0, 1'b1, 32'h11AA3344, 1'b0);
        issue(1'b0, SZ_BYTE, 1'b0, 8'h06, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0);
        issue(1'b0, SZ_BYTE, 1'b1, 8'h06, 32'h0, 1'b1, 32'h000000AA, 1'b0);
        issue(1'b1, SZ_HALF, 1'b0, 8'h08, 32'h00008001, 1'b1, 32'h0, 1'b0);
        issue(1'b0, SZ_HALF, 1'b0, 8'h08, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
        issue(1'b0, SZ_WORD, 1'b0, 8'h08, 32'h0, 1'b1, 32'h00008001, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        issue(1'b1, SZ_WORD, 1'b0, 8'h05, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1);
        issue(1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0, 1'b1, 32'h11AA3344, 1'b0);
`else
        issue(1'b1, SZ_WORD, 1'b0, 8'h05, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        issue(1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
`endif
        issue(1'b0, SZ_WORD, 1'b0, 8'h80, 32'h0, 1'b1, 32'h0, 1'b1);

        // Valid held high across three loads: acceptances must be 3 cycles apart.
        issue(1'b0, SZ_WORD, 1'b0, 8'h00, 32'h0);
        a0 = acc_cyc;
        issue(1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0);
        a1 = acc_cyc;
        issue(1'b0, SZ_WORD, 1'b0, 8'h08, 32'h0);
        a2 = acc_cyc;
        check32("b2b_gap_1", 32'(a1 - a0), 32'd3);
        check32("b2b_gap_2", 32'(a2 - a1), 32'd3);
        drain();

        issue(1'b1, SZ_WORD, 1'b0, 8'h10, 32'h01020304);
        drain();
        issue(1'b1, SZ_WORD, 1'b0, 8'h10, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        check32("rst_access_ready", {31'b0, req_ready}, 32'h0);
        check32("rst_access_valid", {31'b0, rsp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        check32("rst_access_rdata", rsp_rdata, 32'h0);
        check32("rst_access_err", {31'b0, rsp_err}, 32'h0);
        rst_n = 1'b1;
        #1;
        check32("rst_release_ready", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        check32("rst_release_ready_cyc", {31'b0, req_ready}, 32'h1);
        issue(1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, 1'b1, 32'h01020304, 1'b0);
        drain();

        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 143)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 3)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
